uart_tx_buffered: RTL and testbench

//  Buffered 8N1 UART transmitter driving the CPU's serial_out pin: the transmit half facing the serial_in receive path.
//  The MEM-stage IO write path pushes bytes into an internal FIFO; a serializer FSM drains the FIFO and emits framed bits.

---
 rtl/uart_tx_buffered_if.sv | 27 ++
 rtl/uart_tx_buffered.sv | 147 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered_if
//   Byte push channel into the buffered UART transmitter. The producer (the
//   MEM-stage IO write path) offers a byte with data_in_valid; the transmitter
//   FIFO accepts it on any clock edge where data_in_ready is also high.
//
//   data_in        producer -> tx   byte to transmit
//   data_in_valid  producer -> tx   data_in is offered this cycle
//   data_in_ready  tx -> producer   FIFO has room for one more byte
// ----------------------------------------------------------------------------
interface uart_tx_buffered_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered
//   Buffered 8N1 UART transmitter. Bytes pushed through tx_if land in a DEPTH
//   entry FIFO; a serializer FSM drains it and drives serial_out with
//   idle-high framing: start bit (0), 8 data bits LSB first, stop bit (1).
//   Back-to-back frames leave no idle gap when the FIFO still holds data at
//   the end of a stop bit.
//
//   clk         core clock
//   rst         synchronous active-high reset; aborts any frame, flushes FIFO
//   tx_if       slave side of the byte push channel (data/valid/ready)
//   serial_out  registered UART TX line
//   tx_busy     registered: FSM not idle or FIFO not empty
//   fifo_count  bytes waiting in the FIFO (excludes the byte being shifted)
// ----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_tx_buffered_if.slave            tx_if,
    output logic                         serial_out,
    output logic                         tx_busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      mem [DEPTH];
    // Pointers carry one extra bit above the index so full and empty differ.
    logic [CW-1:0]   wr_ptr_q, rd_ptr_q;
    logic            push, pop, baud_last, line_d;

    assign fifo_count          = wr_ptr_q - rd_ptr_q;
    assign tx_if.data_in_ready = (fifo_count != CW'(DEPTH));
    assign push                = tx_if.data_in_valid && tx_if.data_in_ready;
    assign baud_last           = (baud_cnt_q == BAUD_LAST);

    // ------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d = state_q;
        pop     = 1'b0;
        line_d  = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                line_d = 1'b0;
                if (baud_last) state_d = S_DATA;
            end
            S_DATA: begin
                line_d = shift_q[0];
                if (baud_last && bit_idx_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: begin
                // Popping on the final stop cycle chains the next start bit
                // directly after this stop bit.
                if (baud_last) begin
                    if (fifo_count != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM, baud timing, shifter, FIFO pointers, registered line outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            state_q <= state_d;

            // Restart on every state entry and at each bit boundary; idle
            // keeps the counter parked at zero.
            if (state_d != state_q || state_q == S_IDLE || baud_last)
                baud_cnt_q <= '0;
            else
                baud_cnt_q <= baud_cnt_q + 1'b1;

            if (state_q != S_DATA)
                bit_idx_q <= '0;
            else if (baud_last)
                bit_idx_q <= bit_idx_q + 3'd1;

            if (pop)
                shift_q <= mem[rd_ptr_q[AW-1:0]];
            else if (state_q == S_DATA && baud_last)
                shift_q <= {1'b0, shift_q[7:1]};

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            // Both line outputs trail the FSM by one cycle so they come
            // straight from flops and stay aligned with each other.
            serial_out <= line_d;
            tx_busy    <= (state_q != S_IDLE) || (fifo_count != '0);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers alone define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= tx_if.data_in;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Directed bench for uart_tx_buffered at default parameters (CPB = 434).
//   A line-level receiver model decodes serial_out into rx_q; a cycle model
//   of the expected waveform is compared against serial_out every cycle.
//   Cycle n means "sampled 1 time unit after the n-th clock edge following
//   reset release".
// ----------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int CPB   = 434;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_out;
    logic       tx_busy;
    logic [3:0] fifo_count;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cyc           = 0;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_buffered_if tx_if ();

    uart_tx_buffered #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (115_200),
        .DEPTH      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_if      (tx_if),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        tx_if.data_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cyc = -1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_if.data_in       = b;
        tx_if.data_in_valid = 1'b1;
        tick();
        tx_if.data_in_valid = 1'b0;
    endtask

    // Expected line level at cycle c for frames of exp_q starting at cycle 2.
    function automatic logic exp_line(input int c);
        int f, off;
        logic [7:0] b;
        if (c < 2) return 1'b1;
        f = (c - 2) / FRAME;
        if (f >= exp_q.size()) return 1'b1;
        off = (c - 2) % FRAME;
        if (off < CPB) return 1'b0;
        if (off >= 9 * CPB) return 1'b1;
        b = exp_q[f];
        return b[(off - CPB) / CPB];
    endfunction

    // Compare serial_out with the model from the current cycle to last_cyc.
    task automatic run_wave(input string tag, input int last_cyc);
        int first_bad = -1;
        forever begin
            if (serial_out !== exp_line(cyc) && first_bad < 0) first_bad = cyc;
            if (cyc >= last_cyc) break;
            tick();
        end
        check(tag, first_bad, -1);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n = 0;
        while (tx_busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, tx_busy, 0);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] got;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) got = rx_q[i];
            else                 got = 'x;
            check($sformatf("%s_byte%0d", tag, i), got, exp_q[i]);
        end
    endtask

    // Receiver model: mid-bit sampling from the detected falling edge.
    initial begin
        int   mon_cnt;
        int   mon_k;
        bit   mon_active;
        logic mon_prev;
        logic [7:0] mon_sh;
        mon_cnt    = 0;
        mon_active = 1'b0;
        mon_prev   = 1'b1;
        mon_sh     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
                mon_prev   = 1'b1;
            end else begin
                if (!mon_active) begin
                    if (mon_prev === 1'b1 && serial_out === 1'b0) begin
                        mon_active = 1'b1;
                        mon_cnt    = 0;
                    end
                end else begin
                    mon_cnt++;
                end
                if (mon_active && mon_cnt >= CPB / 2 && (mon_cnt - CPB / 2) % CPB == 0) begin
                    mon_k = (mon_cnt - CPB / 2) / CPB;
                    if (mon_k == 0) begin
                        check("rx_start_bit", serial_out, 0);
                    end else if (mon_k <= 8) begin
                        mon_sh[mon_k - 1] = serial_out;
                    end else begin
                        check("rx_stop_bit", serial_out, 1);
                        rx_q.push_back(mon_sh);
                        mon_active = 1'b0;
                    end
                end
                mon_prev = serial_out;
            end
        end
    end

    initial begin
        int   idx, first_full, full_cnt, accept9, low_at;
        logic rdy;

        rst                 = 1'b1;
        tx_if.data_in       = '0;
        tx_if.data_in_valid = 1'b0;

        // Reset state
        do_reset();
        check("rst_serial_out", serial_out, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_ready", tx_if.data_in_ready, 1);
        check("rst_tx_busy", tx_busy, 0);

        // Single byte 0xA5
        rx_q.delete();
        exp_q = {8'hA5};
        push_byte(8'hA5);
        check("a5_count_c0", fifo_count, 1);
        check("a5_line_c0", serial_out, 1);
        tick();
        check("a5_count_c1", fifo_count, 0);
        run_wave("a5_wave_first_bad_cycle", 4341);
        check("a5_busy_c4341", tx_busy, 1);
        tick();
        check("a5_line_c4342", serial_out, 1);
        check("a5_busy_c4342", tx_busy, 0);
        check_rx("a5_rx");

        // Back-to-back 0x00, 0xFF, 0x55
        do_reset();
        rx_q.delete();
        exp_q = {8'h00, 8'hFF, 8'h55};
        tx_if.data_in_valid = 1'b1;
        tx_if.data_in = 8'h00; tick();
        tx_if.data_in = 8'hFF; tick();
        tx_if.data_in = 8'h55; tick();
        tx_if.data_in_valid = 1'b0;
        check("b2b_count_c2", fifo_count, 2);
        run_wave("b2b_wave_first_bad_cycle", 13021);
        check("b2b_busy_c13021", tx_busy, 1);
        tick();
        check("b2b_line_c13022", serial_out, 1);
        check("b2b_busy_c13022", tx_busy, 0);
        check_rx("b2b_rx");

        // Backpressure: valid held with bytes 0..9
        do_reset();
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
        idx = 0; first_full = -1; full_cnt = -1; accept9 = -1;
        while (idx < 10 && cyc < 6000) begin
            tx_if.data_in       = 8'(idx);
            tx_if.data_in_valid = 1'b1;
            rdy = tx_if.data_in_ready;
            tick();
            if (rdy) begin
                if (idx == 9) accept9 = cyc;
                idx++;
            end
            if (!tx_if.data_in_ready && first_full < 0) begin
                first_full = cyc;
                full_cnt   = fifo_count;
            end
        end
        tx_if.data_in_valid = 1'b0;
        check("bp_all_accepted", idx, 10);
        check("bp_ready_low_cycle", first_full, 8);
        check("bp_count_when_full", full_cnt, 8);
        check("bp_byte9_edge_after_2nd_pop", accept9, 4342);
        wait_idle("bp_idle", 50000);
        check_rx("bp_rx");

        // Reset during data bit 3 of 0x3C with two bytes queued
        do_reset();
        rx_q.delete();
        push_byte(8'h3C);
        push_byte(8'h11);
        push_byte(8'h22);
        while (cyc < 1900) tick();
        check("mid_line_bit3", serial_out, 1);
        check("mid_count_before", fifo_count, 2);
        check("mid_busy_before", tx_busy, 1);
        rst                 = 1'b1;
        tx_if.data_in       = 8'h77;
        tx_if.data_in_valid = 1'b1;
        tick();
        rst                 = 1'b0;
        tx_if.data_in_valid = 1'b0;
        check("mid_rst_line", serial_out, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_ready", tx_if.data_in_ready, 1);
        low_at = -1;
        repeat (900) begin
            tick();
            if (serial_out !== 1'b1 && low_at < 0) low_at = cyc;
        end
        check("mid_line_quiet_after_rst", low_at, -1);
        check("mid_no_partial_rx", rx_q.size(), 0);
        exp_q = {8'h81};
        cyc = -1;
        push_byte(8'h81);
        run_wave("mid_81_wave_first_bad_cycle", 4341);
        wait_idle("mid_81_idle", 10);
        check_rx("mid_81_rx");

        // Push colliding with the pop on the last stop cycle
        do_reset();
        rx_q.delete();
        exp_q = {8'h5A, 8'h6B, 8'h7C};
        push_byte(8'h5A);
        push_byte(8'h6B);
        while (cyc < 4340) tick();
        check("col_count_before", fifo_count, 1);
        check("col_stop_line", serial_out, 1);
        push_byte(8'h7C);
        check("col_count_after", fifo_count, 1);
        run_wave("col_wave_first_bad_cycle", 13021);
        wait_idle("col_idle", 10);
        check_rx("col_rx");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
